pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/npu_clk_pkg.sv | 17 +
 rtl/sync_bit.sv | 20 ++
 rtl/pll_lock_sequencer.sv | 128 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/npu_clk_pkg.sv
// Shared clocking constants and the PLL lock sequencer state encoding.
package npu_clk_pkg;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_STABLE_CYCLES   = 1024;
  localparam int DEF_RST_HOLD_CYCLES = 16;
  localparam int DEF_CNT_W           = 8;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } pll_state_e;

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous active-high clear.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[STAGES-2:0], d};
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds downstream logic in reset until the PLL lock has been stable, flags lock loss.
// Optional macro PLL_LOCK_LOSS_CNT_EN adds a saturating lock-loss event counter.
//
// state        | meaning
// ST_WAIT_LOCK | waiting for synchronized lock
// ST_STABLE    | counting STABLE_CYCLES of continuous lock
// ST_HOLD      | lock qualified, keeping sys_rst high RST_HOLD_CYCLES more
// ST_RUN       | downstream released, ready high
// ST_LOST      | one-cycle lock-loss marker
module pll_lock_sequencer
  import npu_clk_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             lock_lost_clr,
  output logic             sys_rst,
  output logic             ready,
  output logic             lock_lost
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,
  output logic [CNT_W-1:0] lock_loss_cnt
`endif
);

  localparam int CNT_MAX = (STABLE_CYCLES > RST_HOLD_CYCLES) ? STABLE_CYCLES - 1
                                                             : RST_HOLD_CYCLES - 1;
  localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LD_STABLE = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LD_HOLD   = CW'(RST_HOLD_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (STABLE_CYCLES < 1 || RST_HOLD_CYCLES < 1) begin : g_bad_cycles
    $error("STABLE_CYCLES and RST_HOLD_CYCLES must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be >= 1");
  end

  logic          w_lock_s;
  logic          w_lost_entry;
  pll_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_sys_rst, r_ready, r_lock_lost;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (w_lock_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = LD_STABLE;
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = LD_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (!w_lock_s)          w_state_nxt = ST_WAIT_LOCK;
        else if (r_cnt == '0)   w_state_nxt = ST_RUN;
        else                    w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_RUN: begin
        if (!w_lock_s) w_state_nxt = ST_LOST;
      end
      ST_LOST: w_state_nxt = ST_WAIT_LOCK;
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  assign w_lost_entry = (r_state == ST_RUN) && !w_lock_s;

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_WAIT_LOCK;
      r_cnt       <= '0;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sys_rst <= (w_state_nxt != ST_RUN);
      r_ready   <= (w_state_nxt == ST_RUN);
      if (w_lost_entry)       r_lock_lost <= 1'b1;
      else if (lock_lost_clr) r_lock_lost <= 1'b0;
    end
  end

  assign sys_rst   = r_sys_rst;
  assign ready     = r_ready;
  assign lock_lost = r_lock_lost;

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] r_loss_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                 r_loss_cnt <= '0;
    else if (w_lost_entry && !(&r_loss_cnt)) r_loss_cnt <= r_loss_cnt + 1'b1;
  end

  assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer (SYNC 2, STABLE 8, HOLD 4, CNT_W 2).
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       lock_lost_clr;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [1:0] lock_loss_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .SYNC_STAGES     (2),
    .STABLE_CYCLES   (8),
    .RST_HOLD_CYCLES (4),
    .CNT_W           (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .lock_lost_clr (lock_lost_clr),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .lock_lost     (lock_lost)
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

`ifndef PLL_LOCK_LOSS_CNT_EN
  assign lock_loss_cnt = 2'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk(tag, 32'(lock_loss_cnt), 32'(exp_cnt));
`endif
  endtask

  // pll_lock -> lock_s takes 2 edges, then 13 edges to RUN: ready on the 15th edge.
  task automatic relock(input string tag);
    pll_lock = 1'b1;
    step(14);
    chk({tag, "_ready_early"}, 32'(ready), 32'd0);
    step(1);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd0);
  endtask

  task automatic lose(input string tag, input logic clr_at_entry);
    pll_lock = 1'b0;
    step(2);
    chk({tag, "_still_run"}, 32'(ready), 32'd1);
    lock_lost_clr = clr_at_entry;
    step(1);
    lock_lost_clr = 1'b0;
    if (exp_cnt < 3) exp_cnt++;
    chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_lock_lost"}, 32'(lock_lost), 32'd1);
    chk_cnt({tag, "_cnt"});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pll_lock = 1'b0;
    lock_lost_clr = 1'b0;
    step(3);
    chk("rst_sys_rst", 32'(sys_rst), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_lock_lost", 32'(lock_lost), 32'd0);
    chk_cnt("rst_cnt");
    rst = 1'b0;
    step(5);
    chk("nolock_ready", 32'(ready), 32'd0);
    chk("nolock_sys_rst", 32'(sys_rst), 32'd1);

    relock("first");
    step(10);
    chk("run_steady", 32'(ready), 32'd1);

    lose("loss1", 1'b0);

    // Glitch mid-STABLE: lock_s low during STABLE must restart qualification.
    pll_lock = 1'b1;
    step(6);
    pll_lock = 1'b0;
    step(3);
    chk("glitch_ready", 32'(ready), 32'd0);
    relock("after_glitch");
    chk("glitch_lost_kept", 32'(lock_lost), 32'd1);

    for (int i = 2; i <= 4; i++) begin
      lose($sformatf("loss%0d", i), 1'b0);
      relock($sformatf("relock%0d", i));
    end

    lock_lost_clr = 1'b1;
    step(1);
    lock_lost_clr = 1'b0;
    chk("clr_lock_lost", 32'(lock_lost), 32'd0);
    chk_cnt("clr_cnt_kept");

    lose("loss5_clr_race", 1'b1);
    relock("relock5");

    rst = 1'b1;
    step(1);
    exp_cnt = 0;
    chk("runrst_sys_rst", 32'(sys_rst), 32'd1);
    chk("runrst_ready", 32'(ready), 32'd0);
    chk("runrst_lock_lost", 32'(lock_lost), 32'd0);
    chk_cnt("runrst_cnt");
    step(2);
    rst = 1'b0;
    relock("post_rst");
    chk("post_rst_lock_lost", 32'(lock_lost), 32'd0);
    chk_cnt("post_rst_cnt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
